// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// datapath mux selects and ALU operations.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECUTER;
            OP_ITYPE:          return S_EXECUTEI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation for R- and I-type arithmetic and
// flags encodings this core does not implement.
module alu_decoder
    import controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_control = ALU_XOR;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            3'b010:  alu_control = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: registered state, outputs decoded from state
// and the current instruction fields.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl
);

    state_t     state_q, state_d;
    logic [2:0] alu_ctl;
    logic       alu_legal;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (state_q == S_EXECUTER),
        .alu_control (alu_ctl),
        .legal       (alu_legal)
    );

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        Illegal    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                state_d = decode_next(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = (state_q == S_EXECUTER) ? SRCB_RS2 : SRCB_IMM;
                ALUControl = alu_ctl;
                state_d    = alu_legal ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = ALU_SUB;
                case (funct3)
                    3'b000:  begin PCWrite = Zero;  state_d = S_FETCH; end
                    3'b001:  begin PCWrite = ~Zero; state_d = S_FETCH; end
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                state_d = S_ALUWB;
            end
            S_LUI, S_AUIPC: begin
                ALUSrcA = (state_q == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
                if (HALT_ON_ILLEGAL == 0) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // NOTE: enables are gated by reset_n directly; the flop alone cannot stop FETCH from echoing MemReady.
        if (!reset_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, hand
// sequences for stalls/reset/illegal, and random instructions vs a reference model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_control;
    } out_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       exp;
    } vec_t;

    typedef struct {
        logic  mr;
        out_t  exp;
        string tag;
    } step_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;

    logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, Illegal_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b;
    logic [2:0] ImmSrc_b, ALUControl_b;

    int n_tests = 0;
    int n_fail  = 0;

    step_t q[$];
    vec_t  vecs[$];

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_ITYPE  = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    multicycle_controller #(.HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .Illegal(Illegal), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
        .RegWrite(RegWrite_b), .Illegal(Illegal_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b),
        .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .ALUControl(ALUControl_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(input logic pcw, adr, mw, irw, rw, ill,
                                input logic [1:0] rs, sa, sb,
                                input logic [2:0] imm, alu);
        out_t o;
        o.pc_write = pcw; o.adr_src = adr; o.mem_write = mw; o.ir_write = irw;
        o.reg_write = rw; o.illegal = ill; o.result_src = rs; o.alu_src_a = sa;
        o.alu_src_b = sb; o.imm_src = imm; o.alu_control = alu;
        return o;
    endfunction

    function automatic out_t got_a();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    endfunction

    function automatic out_t got_b();
        return {PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, Illegal_b,
                ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUControl_b};
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: ALU operation for an arithmetic instruction, -1 if unsupported.
    function automatic int alu_ref(input logic [2:0] f3, input logic f7, input bit r);
        case (f3)
            3'b000:  return (r && f7) ? 1 : 0;
            3'b100:  return 4;
            3'b110:  return 3;
            3'b111:  return 2;
            3'b010:  return 5;
            default: return -1;
        endcase
    endfunction

    function automatic out_t e_fetch(input logic mr);
        return mk(mr, 0, 0, mr, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
    endfunction
    function automatic out_t e_decode(input logic [6:0] o);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, (o == T_JAL) ? 3'b011 : 3'b010, 3'b000);
    endfunction
    function automatic out_t e_memadr(input logic [6:0] o);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, (o == T_STORE) ? 3'b001 : 3'b000, 3'b000);
    endfunction
    function automatic out_t e_exec(input bit r, input logic [2:0] f3, input logic f7);
        int a = alu_ref(f3, f7, r);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, r ? 2'b00 : 2'b01, 3'b000,
                  (a < 0) ? 3'b000 : 3'(a));
    endfunction
    function automatic out_t e_branch(input logic [2:0] f3, input logic z);
        logic pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
        return mk(pcw, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001);
    endfunction

    localparam out_t E_MEMREAD  = '{adr_src: 1'b1, default: '0};
    localparam out_t E_MEMWB    = '{reg_write: 1'b1, result_src: 2'b01, default: '0};
    localparam out_t E_MEMWRITE = '{adr_src: 1'b1, mem_write: 1'b1, default: '0};
    localparam out_t E_ALUWB    = '{reg_write: 1'b1, default: '0};
    localparam out_t E_JALR     = '{alu_src_a: 2'b10, alu_src_b: 2'b01, default: '0};
    localparam out_t E_JAL      = '{pc_write: 1'b1, alu_src_a: 2'b01, alu_src_b: 2'b10, default: '0};
    localparam out_t E_LUI      = '{alu_src_a: 2'b11, alu_src_b: 2'b01, imm_src: 3'b100, default: '0};
    localparam out_t E_AUIPC    = '{alu_src_a: 2'b01, alu_src_b: 2'b01, imm_src: 3'b100, default: '0};
    localparam out_t E_ILLEGAL  = '{illegal: 1'b1, default: '0};

    task automatic push(input logic mr, input out_t exp, input string tag);
        step_t s;
        s.mr = mr; s.exp = exp; s.tag = tag;
        q.push_back(s);
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, from FETCH onward.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fstall, input int mstall, output bit ends_illegal);
        bit bad = 0;
        repeat (fstall) push(1'b0, e_fetch(1'b0), "fetch_stall");
        push(1'b1, e_fetch(1'b1), "fetch");
        push(rbit(), e_decode(o), "decode");
        case (o)
            T_LOAD: begin
                push(rbit(), e_memadr(o), "memadr");
                repeat (mstall) push(1'b0, E_MEMREAD, "memread_stall");
                push(1'b1, E_MEMREAD, "memread");
                push(rbit(), E_MEMWB, "memwb");
            end
            T_STORE: begin
                push(rbit(), e_memadr(o), "memadr");
                repeat (mstall) push(1'b0, E_MEMWRITE, "memwrite_stall");
                push(1'b1, E_MEMWRITE, "memwrite");
            end
            T_RTYPE, T_ITYPE: begin
                push(rbit(), e_exec(o == T_RTYPE, f3, f7), "execute");
                if (alu_ref(f3, f7, o == T_RTYPE) < 0) bad = 1;
                else push(rbit(), E_ALUWB, "aluwb");
            end
            T_BRANCH: begin
                push(rbit(), e_branch(f3, z), "branch");
                if (f3 > 3'b001) bad = 1;
            end
            T_JAL:   begin push(rbit(), E_JAL, "jal"); push(rbit(), E_ALUWB, "aluwb"); end
            T_JALR:  begin
                push(rbit(), E_JALR, "jalr"); push(rbit(), E_JAL, "jal"); push(rbit(), E_ALUWB, "aluwb");
            end
            T_LUI:   begin push(rbit(), E_LUI, "lui"); push(rbit(), E_ALUWB, "aluwb"); end
            T_AUIPC: begin push(rbit(), E_AUIPC, "auipc"); push(rbit(), E_ALUWB, "aluwb"); end
            default: bad = 1;
        endcase
        if (bad) repeat (3) push(rbit(), E_ILLEGAL, "illegal_hold");
        ends_illegal = bad;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            MemReady = s.mr;
            @(negedge clk);
            check(s.tag, got_a(), s.exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        MemReady = 1'b1;
        #2;
        check("reset_outputs", got_a(), e_fetch(1'b0));
        MemReady = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    endtask

    initial begin
        logic [6:0] legal_ops [9] = '{T_LOAD, T_STORE, T_RTYPE, T_ITYPE, T_BRANCH,
                                      T_JAL, T_JALR, T_LUI, T_AUIPC};
        bit ill;

        vecs.push_back('{"add",    T_RTYPE,  3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000)});
        vecs.push_back('{"sub",    T_RTYPE,  3'b000, 1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"xor",    T_RTYPE,  3'b100, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b100)});
        vecs.push_back('{"or",     T_RTYPE,  3'b110, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b011)});
        vecs.push_back('{"and",    T_RTYPE,  3'b111, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b010)});
        vecs.push_back('{"slt",    T_RTYPE,  3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b101)});
        vecs.push_back('{"sll_r",  T_RTYPE,  3'b001, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000)});
        vecs.push_back('{"addi_f7",T_ITYPE,  3'b000, 1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000)});
        vecs.push_back('{"slti",   T_ITYPE,  3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b101)});
        vecs.push_back('{"andi",   T_ITYPE,  3'b111, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b010)});
        vecs.push_back('{"lw",     T_LOAD,   3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000)});
        vecs.push_back('{"sw",     T_STORE,  3'b010, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000)});
        vecs.push_back('{"beq_z1", T_BRANCH, 3'b000, 1'b0, 1'b1, mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"beq_z0", T_BRANCH, 3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"bne_z0", T_BRANCH, 3'b001, 1'b0, 1'b0, mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"bne_z1", T_BRANCH, 3'b001, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"blt_z1", T_BRANCH, 3'b100, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001)});
        vecs.push_back('{"jal",    T_JAL,    3'b000, 1'b0, 1'b0, mk(1,0,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000)});
        vecs.push_back('{"jalr",   T_JALR,   3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000)});
        vecs.push_back('{"lui",    T_LUI,    3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,3'b000)});
        vecs.push_back('{"auipc",  T_AUIPC,  3'b000, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,3'b000)});
        vecs.push_back('{"op_zero",7'b0000000,3'b000,1'b0, 1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000)});
        vecs.push_back('{"op_ones",7'b1111111,3'b000,1'b0, 1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000)});

        set_instr(T_RTYPE, 3'b000, 1'b0, 1'b0);
        MemReady = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("initial_reset", got_a(), e_fetch(1'b0));
        @(posedge clk); #1;
        do_reset();

        // Table: third cycle of each instruction with MemReady held high.
        foreach (vecs[i]) begin
            do_reset();
            set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            MemReady = 1'b1;
            @(posedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            check({"vec_", vecs[i].name}, got_a(), vecs[i].exp);
            @(posedge clk); #1;
        end

        // add x3,x1,x2: RegWrite only in the fourth cycle.
        do_reset();
        set_instr(T_RTYPE, 3'b000, 1'b0, 1'b0);
        build(T_RTYPE, 3'b000, 1'b0, 1'b0, 0, 0, ill);
        run_queue();

        // lw with two MemReady-low cycles in MEMREAD.
        set_instr(T_LOAD, 3'b010, 1'b0, 1'b0);
        build(T_LOAD, 3'b010, 1'b0, 1'b0, 0, 2, ill);
        run_queue();

        // bne taken and not taken.
        set_instr(T_BRANCH, 3'b001, 1'b0, 1'b0);
        build(T_BRANCH, 3'b001, 1'b0, 1'b0, 1, 0, ill);
        run_queue();
        set_instr(T_BRANCH, 3'b001, 1'b0, 1'b1);
        build(T_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, ill);
        run_queue();

        // jal.
        set_instr(T_JAL, 3'b000, 1'b0, 1'b0);
        build(T_JAL, 3'b000, 1'b0, 1'b0, 0, 0, ill);
        run_queue();

        // Illegal opcode: halting instance holds, non-halting instance returns to FETCH.
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1), "ill_fetch");
        push(1'b0, e_decode(7'b0000000), "ill_decode");
        run_queue();
        for (int i = 0; i < 10; i++) begin
            MemReady = 1'b0;
            @(negedge clk);
            check("illegal_held", got_a(), E_ILLEGAL);
            if (i == 0) check("nohalt_illegal", got_b(), E_ILLEGAL);
            if (i == 1) check("nohalt_refetch", got_b(), e_fetch(1'b0));
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        check("illegal_cleared", got_a(), e_fetch(1'b0));
        @(posedge clk); #1;

        // sw interrupted by reset while MemWrite is asserted.
        set_instr(T_STORE, 3'b010, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1), "sw_fetch");
        push(1'b0, e_decode(T_STORE), "sw_decode");
        push(1'b0, e_memadr(T_STORE), "sw_memadr");
        push(1'b0, E_MEMWRITE, "sw_memwrite");
        run_queue();
        MemReady = 1'b0;
        #2;
        check("sw_memwrite_held", got_a(), E_MEMWRITE);
        reset_n = 1'b0;
        #1;
        check("sw_reset_abort", got_a(), e_fetch(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_instr(T_LUI, 3'b000, 1'b0, 1'b0);
        build(T_LUI, 3'b000, 1'b0, 1'b0, 0, 0, ill);
        run_queue();

        // Random instruction stream against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            logic       f7, z;
            o  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            f7 = rbit();
            z  = rbit();
            set_instr(o, f3, f7, z);
            build(o, f3, f7, z, $urandom_range(0, 2), $urandom_range(0, 2), ill);
            run_queue();
            if (ill) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
